// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder and its adder4 datapath:
// nibble width and the sequencer state encoding.
package nibble_serial_adder_pkg;

    localparam int NIB_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        ADD  = 1'b1
    } state_t;

endpackage

// File: rtl/nibble_serial_adder_adder4.sv
// adder4: 4-bit ripple-carry adder, one full adder per bit.
module adder4
    import nibble_serial_adder_pkg::*;
(
    output logic             cout,
    output logic [NIB_W-1:0] sum,
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin
);

    logic [NIB_W:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < NIB_W; i++) begin : g_bit
        assign sum[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[NIB_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: adds two NIBBLES*4-bit operands one nibble per clock through a single adder4.
// Optional macro NSA_SUBTRACT_EN adds a 'sub' input selecting A - B.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] op_a,
    input  logic [4*NIBBLES-1:0] op_b,
    input  logic                 cin,
`ifdef NSA_SUBTRACT_EN
    input  logic                 sub,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] result,
    output logic                 cout
);

    localparam int W     = NIB_W * NIBBLES;
    localparam int CNT_W = (NIBBLES <= 2) ? 1 : $clog2(NIBBLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [W-1:0]     acc;
    logic             sub_en;
    logic [NIB_W-1:0] nib_sum;
    logic             nib_cout;

`ifdef NSA_SUBTRACT_EN
    assign sub_en = sub;
`else
    assign sub_en = 1'b0;
`endif

    // Operands shift right, so the active nibble always sits in bits [3:0].
    adder4 u_adder4 (
        .cout (nib_cout),
        .sum  (nib_sum),
        .a    (a_q[NIB_W-1:0]),
        .b    (b_q[NIB_W-1:0]),
        .cin  (carry)
    );

    assign busy = (state == ADD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            carry  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            acc    <= '0;
            done   <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= op_a;
                        b_q   <= sub_en ? ~op_b : op_b;
                        carry <= sub_en ? 1'b1 : cin;
                        cnt   <= '0;
                        state <= ADD;
                    end
                end
                ADD: begin
                    a_q   <= a_q >> NIB_W;
                    b_q   <= b_q >> NIB_W;
                    acc   <= {nib_sum, acc[W-1:NIB_W]};
                    carry <= nib_cout;
                    cnt   <= cnt + CNT_W'(1);
                    // Outputs only move on the final nibble, never showing partial sums.
                    if (cnt == LAST) begin
                        result <= {nib_sum, acc[W-1:NIB_W]};
                        cout   <= nib_cout;
                        done   <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
